fmul_seq: RTL and testbench
===========================

Name: fmul_seq

Overview:
- Multi-cycle IEEE-754 floating-point multiplier. It is the multiplicative counterpart of the combinational significand divider in the FP unit.
- It uses the same unpacked classification and the same flag vector, and is parameterised by NEXP/NSIG like the divider.
- A radix-2 shift-add significand multiplier replaces the wide combinational product.
- It sits beside the divider behind the FPU issue logic and uses a start/busy/done handshake.

Parameters:
- NEXP, 8, exponent width.
- NSIG, 23, stored fraction width. M = NSIG+1 is the significand width including the hidden bit. W = 1+NEXP+NSIG.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request. Sampled only when busy=0.
- a  in  W  multiplicand, captured when start is accepted.
- b  in  W  multiplier, captured when start is accepted.
- round_mode  in  1  0 = truncate, 1 = round-to-nearest-even. Captured when start is accepted.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when y/flags become valid.
- y  out  W  result. Held until the next done.
- flags  out  5  {invalid, div0, ovf, udf, inx}. Held with y. div0 is always 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, y=0, flags=0, counter=0. All internal registers are cleared.
- Reset mid-operation: the operation is abandoned and no done is issued.
- States:
  - IDLE: on start, latch a, b and round_mode; sign = a[W-1]^b[W-1]. Unpack both operands: exponent unbiased; subnormal significand has hidden bit 0 and exponent 1-bias. Clear the 2M-bit accumulator, load the counter with M, go to MUL. busy=1 from the next cycle.
  - MUL: one iteration per cycle. If the multiplier LSB is 1, add the multiplicand into the upper accumulator half. Shift the accumulator/multiplier pair right by 1 and decrement the counter. After M iterations (counter reaches 0) go to RND.
  - RND: one cycle. Normalisation, exponent, sticky, rounding and packing are described below. Write y/flags, assert done for exactly this cycle, clear busy, return to IDLE.
- Normalisation in RND:
  - Leading-one detect on the 2M-bit product.
  - Shift so the MSB sits at bit 2M-1.
  - Exponent = aExp+bExp+1-shift.
- Sticky in RND: the OR of all bits below guard and round.
- Rounding and packing in RND:
  - Round with the latched mode. A carry-out of rounding renormalises and increments the exponent.
  - If the exponent is below the minimum, right-shift into subnormal range before rounding; shifted-out bits join sticky.
  - udf is set when the result is tiny (detected before rounding) and inexact.
  - On exponent overflow, ovf=1 and inx=1. The result is ±Inf in nearest mode and ±max-finite in truncate mode.
  - inx is set whenever guard, round or sticky is nonzero.
- Fixed latency: done is high exactly M+2 cycles after the start-accept edge (26 for defaults). This applies to every operand class, and the significand datapath still iterates for specials.
- Special cases, resolved in RND with this priority:
  - sNaN on either operand → 0x7FC00000-style canonical qNaN {0, all ones, 1, zeros}, invalid=1.
  - qNaN on either operand → canonical qNaN, no flags.
  - Inf×0 or 0×Inf → canonical qNaN, invalid=1.
  - Inf×finite/Inf → ±Inf, no flags.
  - 0×finite → ±0, no flags.
- start while busy=1 is ignored; no queueing.
- start in the same cycle as done is accepted, because done occurs in RND and the FSM is back in IDLE the next cycle. Back-to-back issue therefore spaces done pulses exactly M+2 cycles apart.
- Input changes after acceptance have no effect.

Test Plan:
- Exact product: a=0x40000000, b=0x40400000, rm=1 → done at cycle 26, y=0x40C00000, flags=00000. a=0x3FC00000 squared → y=0x40100000, flags=00000.
- Inexact rounding: a=b=0x3F800001 → y=0x3F800002, flags=00001 in both modes. a=0x3FFFFFFF, b=0x3FFFFFFF, rm=0 → y=0x407FFFFE, flags=00001.
- Overflow: a=0x7F7FFFFF, b=0x40000000:
  - rm=1 → y=0x7F800000, flags=00101.
  - rm=0 → y=0x7F7FFFFF, flags=00101.
- Subnormal/underflow: a=0x00000001, b=0x3F000000, rm=1 → y=0x00000000, flags=00011. a=0x00800000, b=0x3F000000 → y=0x00400000, flags=00000.
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, flags=10000.
  - 0x7F800001 × 0x3F800000 → 0x7FC00000, flags=10000.
  - 0xFF800000 × 0x40000000 → 0xFF800000, flags=00000.
- Handshake:
  - start pulsed during busy → ignored.
  - start coincident with done → accepted, second done after 26 cycles.
  - rst_n low at cycle 10 of an operation → busy=0, done never pulses, y=0.

Source files
------------

// File: rtl/fmul_seq.sv
// fmul_seq: multi-cycle IEEE-754 multiplier. A radix-2 shift-add loop builds the
// significand product, then one cycle normalises, rounds, packs and resolves specials.
module fmul_seq #(
  parameter int NEXP = 8,
  parameter int NSIG = 23
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NEXP+NSIG:0] a,
  input  logic [NEXP+NSIG:0] b,
  input  logic               round_mode,
  output logic               busy,
  output logic               done,
  output logic [NEXP+NSIG:0] y,
  output logic [4:0]         flags
);
  localparam int M    = NSIG + 1;
  localparam int W    = 1 + NEXP + NSIG;
  localparam int P    = 2 * M;
  localparam int BIAS = (1 << (NEXP - 1)) - 1;
  localparam int SW   = $clog2(P + 1);
  localparam int CW   = $clog2(M + 1);
  localparam int EW   = NEXP + SW + 2;
  localparam int MW   = EW + NSIG;

  localparam logic signed [EW-1:0] EMIN    = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] E_ONE   = EW'(1);
  localparam logic signed [EW-1:0] E_BIAS  = EW'(BIAS);
  localparam logic signed [EW-1:0] E_BM1   = EW'(BIAS - 1);
  localparam logic signed [EW-1:0] P_S     = EW'(P);
  localparam logic [EW-1:0]        EXP_MAX = EW'((1 << NEXP) - 1);
  localparam logic [CW-1:0]        CNT_M   = CW'(M);
  localparam logic [W-1:0]         QNAN    = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RND  = 2'd2
  } state_t;

  function automatic logic signed [EW-1:0] unbias(input logic [NEXP-1:0] f);
    logic signed [EW-1:0] e;
    if (f == {NEXP{1'b0}}) begin
      e = EMIN;
    end else begin
      e = $signed({{(EW-NEXP){1'b0}}, f}) - E_BIAS;
    end
    return e;
  endfunction

  // Position of the leading one counted from the MSB; P when the vector is zero.
  function automatic logic [SW-1:0] lead_zeros(input logic [P-1:0] v);
    logic [SW-1:0] n;
    n = SW'(P);
    for (int i = 0; i < P; i++) begin
      if (v[i]) begin
        n = SW'(P - 1 - i);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  state_t               state_r, next_s;
  logic [W-2:0]         opa_r, opb_r;
  logic                 rm_r, sign_r;
  logic [M-1:0]         ma_r, mb_r;
  logic signed [EW-1:0] ea_r, eb_r;
  logic [P-1:0]         acc_r;
  logic [CW-1:0]        cnt_r;
  logic [W-1:0]         y_r;
  logic [4:0]           flags_r;
  logic                 done_r, busy_r;

  logic [M:0]           addend_s, sum_s;
  logic [SW-1:0]        shift_s;
  logic [P-1:0]         norm_s, den_s;
  logic signed [EW-1:0] exp_s, dist_s, be_m_s;
  logic                 tiny_s, lost_s, guard_s, round_s, sticky_s, inexact_s, inc_s, ovf_s;
  logic [M-1:0]         mant_s;
  logic [MW-1:0]        mag_s;
  logic                 a_nan_s, a_snan_s, a_inf_s, a_zero_s;
  logic                 b_nan_s, b_snan_s, b_inf_s, b_zero_s;
  logic [W-1:0]         res_y_s;
  logic [4:0]           res_f_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic: the MUL state spends one extra cycle once the count hits zero.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_s = MUL;
        else       next_s = IDLE;
      end
      MUL: begin
        if (cnt_r == {CW{1'b0}}) next_s = RND;
        else                     next_s = MUL;
      end
      RND:     next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand into the upper half.
  always_comb begin
    addend_s = mb_r[0] ? {1'b0, ma_r} : {(M+1){1'b0}};
    sum_s    = {1'b0, acc_r[P-1:M]} + addend_s;
  end

  // Normalise, denormalise into subnormal range, round and pack the finite result.
  always_comb begin
    shift_s = lead_zeros(acc_r);
    norm_s  = acc_r << shift_s;
    exp_s   = ea_r + eb_r + E_ONE - $signed({{(EW-SW){1'b0}}, shift_s});
    tiny_s  = (exp_s < EMIN);
    dist_s  = tiny_s ? (EMIN - exp_s) : {EW{1'b0}};
    if (dist_s >= P_S) begin
      den_s  = {P{1'b0}};
      lost_s = |norm_s;
    end else begin
      den_s  = norm_s >> dist_s;
      lost_s = |(norm_s & ~({P{1'b1}} << dist_s));
    end
    mant_s    = den_s[P-1:M];
    guard_s   = den_s[M-1];
    round_s   = den_s[M-2];
    sticky_s  = (|den_s[M-3:0]) | lost_s;
    inexact_s = guard_s | round_s | sticky_s;
    inc_s     = rm_r & guard_s & (round_s | sticky_s | mant_s[0]);
    // Hidden bit adds into the exponent field, so rounding carries renormalise for free.
    be_m_s    = tiny_s ? {EW{1'b0}} : (exp_s + E_BM1);
    mag_s     = {be_m_s, {NSIG{1'b0}}} + MW'(mant_s) + MW'(inc_s);
    ovf_s     = (mag_s[MW-1:NSIG] >= EXP_MAX);
  end

  // Operand classification and special-case priority.
  always_comb begin
    a_nan_s  = (&opa_r[W-2:NSIG]) & (|opa_r[NSIG-1:0]);
    a_snan_s = a_nan_s & ~opa_r[NSIG-1];
    a_inf_s  = (&opa_r[W-2:NSIG]) & ~(|opa_r[NSIG-1:0]);
    a_zero_s = ~(|opa_r);
    b_nan_s  = (&opb_r[W-2:NSIG]) & (|opb_r[NSIG-1:0]);
    b_snan_s = b_nan_s & ~opb_r[NSIG-1];
    b_inf_s  = (&opb_r[W-2:NSIG]) & ~(|opb_r[NSIG-1:0]);
    b_zero_s = ~(|opb_r);
    res_y_s  = {W{1'b0}};
    res_f_s  = 5'b00000;
    if (a_snan_s | b_snan_s) begin
      res_y_s = QNAN;
      res_f_s = 5'b10000;
    end else if (a_nan_s | b_nan_s) begin
      res_y_s = QNAN;
      res_f_s = 5'b00000;
    end else if ((a_inf_s & b_zero_s) | (a_zero_s & b_inf_s)) begin
      res_y_s = QNAN;
      res_f_s = 5'b10000;
    end else if (a_inf_s | b_inf_s) begin
      res_y_s = {sign_r, {NEXP{1'b1}}, {NSIG{1'b0}}};
      res_f_s = 5'b00000;
    end else if (a_zero_s | b_zero_s) begin
      res_y_s = {sign_r, {(W-1){1'b0}}};
      res_f_s = 5'b00000;
    end else if (ovf_s) begin
      if (rm_r) begin
        res_y_s = {sign_r, {NEXP{1'b1}}, {NSIG{1'b0}}};
      end else begin
        res_y_s = {sign_r, {(NEXP-1){1'b1}}, 1'b0, {NSIG{1'b1}}};
      end
      res_f_s = 5'b00101;
    end else begin
      res_y_s = {sign_r, mag_s[W-2:0]};
      res_f_s = {3'b000, tiny_s & inexact_s, inexact_s};
    end
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_r   <= {(W-1){1'b0}};
      opb_r   <= {(W-1){1'b0}};
      rm_r    <= 1'b0;
      sign_r  <= 1'b0;
      ma_r    <= {M{1'b0}};
      mb_r    <= {M{1'b0}};
      ea_r    <= {EW{1'b0}};
      eb_r    <= {EW{1'b0}};
      acc_r   <= {P{1'b0}};
      cnt_r   <= {CW{1'b0}};
      y_r     <= {W{1'b0}};
      flags_r <= 5'b00000;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            opa_r  <= a[W-2:0];
            opb_r  <= b[W-2:0];
            rm_r   <= round_mode;
            sign_r <= a[W-1] ^ b[W-1];
            ma_r   <= {|a[W-2:NSIG], a[NSIG-1:0]};
            mb_r   <= {|b[W-2:NSIG], b[NSIG-1:0]};
            ea_r   <= unbias(a[W-2:NSIG]);
            eb_r   <= unbias(b[W-2:NSIG]);
            acc_r  <= {P{1'b0}};
            cnt_r  <= CNT_M;
            busy_r <= 1'b1;
          end
        end
        MUL: begin
          if (cnt_r != {CW{1'b0}}) begin
            acc_r <= {sum_s, acc_r[M-1:1]};
            mb_r  <= {1'b0, mb_r[M-1:1]};
            cnt_r <= cnt_r - CW'(1);
          end
        end
        RND: begin
          y_r     <= res_y_s;
          flags_r <= res_f_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign y     = y_r;
  assign flags = flags_r;

endmodule

// File: tb/tb_fmul_seq.sv
// Self-checking bench for fmul_seq: directed vectors, random operands against an
// exact-arithmetic IEEE binary32 reference, and handshake/reset scenarios.
module tb_fmul_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        round_mode = 1'b0;
  logic        busy, done;
  logic [31:0] y;
  logic [4:0]  flags;

  int total = 0;
  int bad = 0;

  fmul_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .round_mode(round_mode), .busy(busy), .done(done), .y(y), .flags(flags)
  );

  initial forever #5 clk = ~clk;

  // Reference: exact integer product, then quantise to the binary32 grid.
  function automatic void ref_mul(input logic [31:0] oa, input logic [31:0] ob, input logic rm,
                                  output logic [31:0] ry, output logic [4:0] rf);
    logic s, a_nan, a_snan, a_inf, a_zero, b_nan, b_snan, b_inf, b_zero, inexact, tiny;
    logic [63:0] ma, mb, p, sig, rem, half;
    int ea, eb, lsb_e, k, e_val, q, sh, biased;
    s = oa[31] ^ ob[31];
    a_nan  = (oa[30:23] == 8'hFF) && (oa[22:0] != 23'd0);
    a_snan = a_nan && !oa[22];
    a_inf  = (oa[30:23] == 8'hFF) && (oa[22:0] == 23'd0);
    a_zero = (oa[30:0] == 31'd0);
    b_nan  = (ob[30:23] == 8'hFF) && (ob[22:0] != 23'd0);
    b_snan = b_nan && !ob[22];
    b_inf  = (ob[30:23] == 8'hFF) && (ob[22:0] == 23'd0);
    b_zero = (ob[30:0] == 31'd0);
    ry = 32'h0;
    rf = 5'b00000;
    if (a_snan || b_snan) begin
      ry = 32'h7FC00000; rf = 5'b10000;
    end else if (a_nan || b_nan) begin
      ry = 32'h7FC00000; rf = 5'b00000;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      ry = 32'h7FC00000; rf = 5'b10000;
    end else if (a_inf || b_inf) begin
      ry = {s, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      ry = {s, 31'd0};
    end else begin
      ma = {40'd0, (oa[30:23] != 8'd0), oa[22:0]};
      mb = {40'd0, (ob[30:23] != 8'd0), ob[22:0]};
      ea = (oa[30:23] == 8'd0) ? -126 : int'(oa[30:23]) - 127;
      eb = (ob[30:23] == 8'd0) ? -126 : int'(ob[30:23]) - 127;
      p = ma * mb;
      lsb_e = ea + eb - 46;
      k = 47;
      while (k > 0 && !p[k]) k--;
      e_val = lsb_e + k;
      tiny = (e_val < -126);
      q = tiny ? -149 : e_val - 23;
      sh = q - lsb_e;
      if (sh <= 0) begin
        sig = p << (-sh); inexact = 1'b0;
      end else if (sh > 60) begin
        sig = 64'd0; inexact = 1'b1;
      end else begin
        sig = p >> sh;
        rem = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        inexact = (rem != 64'd0);
        if (rm && (rem > half || (rem == half && sig[0]))) sig = sig + 64'd1;
      end
      if (sig == (64'd1 << 24)) begin
        sig = sig >> 1; q = q + 1;
      end
      biased = (sig >= 64'h800000) ? q + 23 + 127 : 0;
      if (biased >= 255) begin
        ry = rm ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF};
        rf = 5'b00101;
      end else begin
        ry = {s, 8'(biased), sig[22:0]};
        rf = {3'b000, tiny && inexact, inexact};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    logic [22:0] f;
    int k;
    k = int'($urandom_range(0, 15));
    case (k)
      0:       e = 8'd0;
      1:       e = 8'hFF;
      2, 3, 4: e = 8'(122 + $urandom_range(0, 10));
      default: e = 8'($urandom_range(1, 254));
    endcase
    f = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  task automatic drive(input logic [31:0] oa, input logic [31:0] ob, input logic orm);
    start = 1'b1; a = oa; b = ob; round_mode = orm;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; round_mode = ~orm;
  endtask

  task automatic wait_done(input int base, output int lat, output logic [31:0] yo, output logic [4:0] fo);
    lat = -1; yo = 32'h0; fo = 5'h0;
    for (int c = base + 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c; yo = y; fo = flags;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, y, flags} !== 39'd0) begin
      bad++;
      $display("FAIL reset: got busy=%b done=%b y=%h flags=%b want all zero", busy, done, y, flags);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [0:13];
    logic [31:0] tb [0:13];
    logic        tr [0:13];
    logic [31:0] ty [0:13];
    logic [4:0]  tf [0:13];
    int lat;
    logic [31:0] yo;
    logic [4:0] fo;
    ta = '{32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h3FFFFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF,
           32'h00000001, 32'h00800000, 32'h7F800000, 32'h7F800001, 32'hFF800000, 32'h7FC00001, 32'h80000000};
    tb = '{32'h40400000, 32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h3FFFFFFF, 32'h40000000, 32'h40000000,
           32'h3F000000, 32'h3F000000, 32'h00000000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F800000};
    tr = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ty = '{32'h40C00000, 32'h40100000, 32'h3F800002, 32'h3F800002, 32'h407FFFFE, 32'h7F800000, 32'h7F7FFFFF,
           32'h00000000, 32'h00400000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h80000000};
    tf = '{5'b00000, 5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00101, 5'b00101,
           5'b00011, 5'b00000, 5'b10000, 5'b10000, 5'b00000, 5'b00000, 5'b00000};
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      drive(ta[i], tb[i], tr[i]);
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL dir[%0d] busy: got %b want 1", i, busy);
      end
      wait_done(0, lat, yo, fo);
      total++;
      if (lat !== 26) begin
        bad++;
        $display("FAIL dir[%0d] latency: got %0d want 26", i, lat);
      end
      total++;
      if (yo !== ty[i] || fo !== tf[i]) begin
        bad++;
        $display("FAIL dir[%0d] result: got y=%h flags=%b want y=%h flags=%b", i, yo, fo, ty[i], tf[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] oa, ob, ey, yo;
    logic [4:0] ef, fo;
    logic orm;
    int lat;
    for (int i = 0; i < 300; i++) begin
      oa = rand_op(); ob = rand_op(); orm = 1'($urandom);
      ref_mul(oa, ob, orm, ey, ef);
      @(posedge clk); #1;
      drive(oa, ob, orm);
      wait_done(0, lat, yo, fo);
      total++;
      if (lat !== 26 || yo !== ey || fo !== ef) begin
        bad++;
        $display("FAIL rand[%0d] %h*%h rm=%b: got lat=%0d y=%h flags=%b want lat=26 y=%h flags=%b",
                 i, oa, ob, orm, lat, yo, fo, ey, ef);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] ey, yo;
    logic [4:0] ef, fo;
    int lat, extra;
    ref_mul(32'h3FC00000, 32'h40400000, 1'b1, ey, ef);
    @(posedge clk); #1;
    drive(32'h3FC00000, 32'h40400000, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    drive(32'h40000000, 32'h40000000, 1'b0);
    wait_done(5, lat, yo, fo);
    total++;
    if (lat !== 26 || yo !== ey || fo !== ef) begin
      bad++;
      $display("FAIL busy_ignore: got lat=%0d y=%h flags=%b want lat=26 y=%h flags=%b", lat, yo, fo, ey, ef);
    end
    extra = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    total++;
    if (extra !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_ignore_extra: got extra_done=%0d busy=%b want 0 and 0", extra, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ey1, ey2, yo;
    logic [4:0] ef1, ef2, fo;
    int lat;
    ref_mul(32'h3F800001, 32'h3F800001, 1'b1, ey1, ef1);
    ref_mul(32'hC0400000, 32'h3FC00000, 1'b0, ey2, ef2);
    @(posedge clk); #1;
    drive(32'h3F800001, 32'h3F800001, 1'b1);
    wait_done(0, lat, yo, fo);
    total++;
    if (lat !== 26 || yo !== ey1 || fo !== ef1) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d y=%h flags=%b want lat=26 y=%h flags=%b", lat, yo, fo, ey1, ef1);
    end
    drive(32'hC0400000, 32'h3FC00000, 1'b0);
    wait_done(0, lat, yo, fo);
    total++;
    if (lat !== 26 || yo !== ey2 || fo !== ef2) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d y=%h flags=%b want lat=26 y=%h flags=%b", lat, yo, fo, ey2, ef2);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    logic [31:0] ey, yo;
    logic [4:0] ef, fo;
    int lat;
    @(posedge clk); #1;
    drive(32'h40000000, 32'h40400000, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || y !== 32'h0 || flags !== 5'b0) begin
      bad++;
      $display("FAIL reset_mid: got busy=%b done=%b y=%h flags=%b want zeros", busy, done, y, flags);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    total++;
    if (pulses !== 0 || busy !== 1'b0 || y !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_quiet: got done_pulses=%0d busy=%b y=%h want 0 0 0", pulses, busy, y);
    end
    ref_mul(32'h3FC00000, 32'h3FC00000, 1'b0, ey, ef);
    @(posedge clk); #1;
    drive(32'h3FC00000, 32'h3FC00000, 1'b0);
    wait_done(0, lat, yo, fo);
    total++;
    if (lat !== 26 || yo !== ey || fo !== ef) begin
      bad++;
      $display("FAIL reset_recover: got lat=%0d y=%h flags=%b want lat=26 y=%h flags=%b", lat, yo, fo, ey, ef);
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
